// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle between the ALU and its requester/consumer
interface alu_multicycle_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, overflow, zero;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, result, result_hi;
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, result_hi, cout, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, result_hi, cout, overflow, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle logic/arith ops plus WIDTH-cycle shift-add unsigned multiply
module alu_multicycle #(parameter int WIDTH = 16) (
  input logic clk,
  input logic reset,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mc_q, mc_d, result_q, result_d, result_hi_q, result_hi_d, res_s;
  logic [2*WIDTH-1:0] p_q, p_d, p_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] sum_add, sum_sub, madd;
  logic cout_q, cout_d, ovf_q, ovf_d, cout_s, ovf_s, ovf_add, ovf_sub;
  logic accept, is_mul, last;
  assign is_mul = bus.op == 3'b011;
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt_q == LAST;
  always_ff @(posedge clk)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == S_MUL ? (last ? S_DONE : S_MUL) :
              accept ? (is_mul ? S_MUL : S_DONE) :
              (state_q == S_DONE && !bus.out_ready) ? S_DONE : S_IDLE;
  always_comb begin
    bus.in_ready = state_q == S_IDLE || (state_q == S_DONE && bus.out_ready);
    bus.out_valid = state_q == S_DONE;
  end
  assign bus.result = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero = result_q == '0;
  assign sum_add = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_add[WIDTH-1] != bus.a[WIDTH-1]);
  assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum_sub[WIDTH-1] != bus.a[WIDTH-1]);
  always_comb begin
    res_s = '0;
    cout_s = 1'b0;
    ovf_s = 1'b0;
    case (bus.op)
      3'b000: res_s = bus.a & bus.b;
      3'b001: res_s = bus.a | bus.b;
      3'b010: {cout_s, res_s, ovf_s} = {sum_add, ovf_add};
      3'b100: res_s = bus.a ^ bus.b;
      3'b101: res_s = ~(bus.a | bus.b);
      3'b110: {cout_s, res_s, ovf_s} = {sum_sub, ovf_sub};
      3'b111: res_s = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
      default: res_s = '0;
    endcase
  end
  assign madd = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mc_q} : '0);
  assign p_nx = {madd, p_q[WIDTH-1:1]};
  always_comb begin
    mc_d = mc_q;
    p_d = p_q;
    cnt_d = cnt_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == S_MUL) begin
      p_d = p_nx;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        result_d = p_nx[WIDTH-1:0];
        result_hi_d = p_nx[2*WIDTH-1:WIDTH];
        cout_d = |p_nx[2*WIDTH-1:WIDTH];
        ovf_d = |p_nx[2*WIDTH-1:WIDTH];
      end
    end
    if (accept && is_mul) begin
      mc_d = bus.a;
      p_d = {{WIDTH{1'b0}}, bus.b};
      cnt_d = '0;
    end
    if (accept && !is_mul) begin
      result_d = res_s;
      result_hi_d = '0;
      cout_d = cout_s;
      ovf_d = ovf_s;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      mc_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      result_hi_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      mc_q <= mc_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on a, b, cin, op.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 cin  input  1  carry-in, used by ADD only.
REQ-008 op  input  3  000 AND, 001 OR, 010 ADD, 011 MUL, 100 XOR, 101 NOR, 110 SUB, 111 SLT.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  low WIDTH bits of outcome.
REQ-012 result_hi  output  WIDTH  MUL upper half; zero for all other ops.
REQ-013 cout, overflow, zero  output  1 each  carry-out, signed overflow, result==0.

Function
REQ-014 States IDLE, MUL, DONE; request accepted when in_valid && in_ready at a rising edge.
REQ-015 in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back single-cycle ops sustain one result per cycle.
REQ-016 Single-cycle ops (all except MUL): accepted at edge N, out_valid=1 with registered result after edge N; latency 1.
REQ-017 ADD: {cout,result} = a + b + cin, unsigned WIDTH+1-bit sum.
REQ-018 SUB: result = a - b computed as a + ~b + 1; cout = 1 when no borrow (a >= b unsigned); cin ignored.
REQ-019 overflow for ADD/SUB: set when operand signs (b inverted for SUB) match and result sign differs; 0 for all other ops.
REQ-020 SLT: result = 1 if a < b signed (sign of a-b XOR overflow of a-b), else 0; cout = overflow = 0.
REQ-021 AND/OR/XOR/NOR bitwise; cout = overflow = 0.
REQ-022 MUL: unsigned radix-2 shift-add; accept -> MUL state, WIDTH iterations, one per cycle, counter of ceil(log2(WIDTH+1)) bits; then DONE.
REQ-023 MUL latency: accepted at edge N, out_valid rises after edge N+WIDTH; {result_hi,result} = a*b; cout = overflow = (result_hi != 0).
REQ-024 in_ready = 0 throughout MUL state; in_valid ignored there.
REQ-025 zero = (result == 0), low half only, for every op including MUL.
REQ-026 DONE: outputs stable while out_ready=0; on out_ready=1 without new accept -> IDLE, out_valid=0.
REQ-027 DONE with out_ready=1 and new accept: result replaced (single-cycle) or MUL entered with out_valid=0 next cycle.
REQ-028 Operands latched at accept; changes on a, b, op afterwards do not affect an in-flight MUL.
REQ-029 Undefined op encodings do not exist (all 8 decoded).

Reset
REQ-030 reset=1 at an edge: state=IDLE, out_valid=0, result=result_hi=0, cout=overflow=0, zero=1, MUL counter=0.
REQ-031 Reset takes priority over any accept or MUL iteration; an in-flight MUL is discarded, no out_valid produced.
REQ-032 in_ready = 1 in the first cycle after reset deasserts.

Verification (WIDTH=16)
REQ-033 ADD a=FFFF b=FFFF cin=0 -> result=FFFE, cout=1, overflow=0, zero=0, out_valid one cycle after accept.
REQ-034 SUB a=8000 b=0001 -> result=7FFF, overflow=1, cout=1; SLT a=8000 b=0001 -> result=0001.
REQ-035 MUL a=FFFF b=FFFF accepted at edge N -> out_valid after edge N+16, result=0001, result_hi=FFFE, cout=1; in_ready=0 edges N+1..N+16.
REQ-036 AND a=4101 b=D205 then OR a=C003 b=0000 back-to-back, out_ready=1 -> results 4001 then C003, one per cycle, in_ready held 1.
REQ-037 out_ready=0 for 5 cycles after ADD 0040+0001 -> result=0041 held stable, in_ready=0, no new accept.
REQ-038 reset asserted mid-MUL (cycle 8) -> next cycle out_valid=0, zero=1, in_ready=1 after release; following ADD 0000+0000 gives zero=1.
